// File: rtl/quiz_pkg.sv
// Shared types and helpers for the quiz sequencer: op codes, FSM states,
// equation record layout and small arithmetic helpers.
package quiz_pkg;

    localparam int ANS_W = 7;
    localparam int SEC_W = 5;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_ANS,
        ST_CHECK,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [ANS_W-1:0] a;
        logic [ANS_W-1:0] b;
        op_t              op;
    } eq_t;

    // Result the player must type, truncated to the answer width.
    function automatic logic [ANS_W-1:0] calc_expected(eq_t e);
        logic [2*ANS_W-1:0] prod;
        prod = {{ANS_W{1'b0}}, e.a} * {{ANS_W{1'b0}}, e.b};
        case (e.op)
            OP_ADD:  return e.a + e.b;
            OP_SUB:  return e.a - e.b;
            OP_MUL:  return prod[ANS_W-1:0];
            default: return '0;
        endcase
    endfunction

    // Mistake counter increment that sticks at 15.
    function automatic logic [3:0] sat_inc(logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/quiz_sequencer_rom.sv
// Fixed table of the four quiz equations, indexed by equation number.
module equation_rom
    import quiz_pkg::*;
(
    input  logic [1:0] idx,
    output eq_t        eq
);

    // Pure lookup, no state.
    always_comb begin
        eq = '{a: 7'd12, b: 7'd7, op: OP_ADD};
        case (idx)
            2'd0: eq = '{a: 7'd12, b: 7'd7,  op: OP_ADD};
            2'd1: eq = '{a: 7'd30, b: 7'd14, op: OP_SUB};
            2'd2: eq = '{a: 7'd6,  b: 7'd9,  op: OP_MUL};
            2'd3: eq = '{a: 7'd25, b: 7'd25, op: OP_ADD};
            default: ;
        endcase
    end

endmodule

// File: rtl/quiz_sequencer.sv
// Equation-phase controller: presents each equation, times the attempt,
// judges the submitted answer and reports round completion.
module quiz_sequencer
    import quiz_pkg::*;
#(
    parameter int CLK_HZ    = 50000000,
    parameter int NUM_EQ    = 3,
    parameter int TIMEOUT_S = 20
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Start,
    input  logic             Go,
    input  logic [ANS_W-1:0] DataIn,
    output logic [1:0]       EqIndex,
    output logic [ANS_W-1:0] OperandA,
    output logic [ANS_W-1:0] OperandB,
    output logic [1:0]       OpSel,
    output logic             Correct,
    output logic             Wrong,
    output logic [3:0]       WrongCount,
    output logic [SEC_W-1:0] SecondsLeft,
    output logic             Busy,
    output logic             Done,
    output logic             NeedSequence
);

    localparam logic [1:0] LAST_EQ = 2'(NUM_EQ - 1);
    localparam int         PW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);

    state_t           state, state_nxt;
    eq_t              rom_eq;
    logic             go_q;
    logic             go_edge;
    logic             tick;
    logic             timeout;
    logic             match;
    logic [PW-1:0]    prescaler;
    logic [ANS_W-1:0] expected;
    logic [ANS_W-1:0] answer;

    equation_rom u_rom (
        .idx (EqIndex),
        .eq  (rom_eq)
    );

    // Go is active low: a submit is the 1->0 transition, so a held key
    // yields a single submission.
    assign go_edge = go_q & ~Go;
    assign tick    = (prescaler == PRE_MAX);
    // The tick that takes the timer to zero expires the attempt, unless a
    // submit arrives in the same cycle.
    assign timeout = tick && (SecondsLeft == SEC_W'(1)) && !go_edge;
    assign match   = (answer == expected);

    assign Busy         = (state == ST_LOAD) || (state == ST_WAIT_ANS) || (state == ST_CHECK);
    assign Done         = (state == ST_DONE);
    assign NeedSequence = Done && (WrongCount != 4'd0);

    // State register.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic; dropping Start aborts from anywhere.
    always_comb begin
        state_nxt = state;
        if (state != ST_IDLE && !Start) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:     if (Start) state_nxt = ST_LOAD;
                ST_LOAD:     state_nxt = ST_WAIT_ANS;
                ST_WAIT_ANS: begin
                    if (go_edge)      state_nxt = ST_CHECK;
                    else if (timeout) state_nxt = ST_LOAD;
                end
                ST_CHECK:    state_nxt = (match && EqIndex == LAST_EQ) ? ST_DONE : ST_LOAD;
                ST_DONE:     state_nxt = ST_DONE;
                default:     state_nxt = ST_IDLE;
            endcase
        end
    end

    // Datapath: operands, timer, answer capture, verdict pulses and score.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            go_q        <= 1'b1;
            prescaler   <= '0;
            expected    <= '0;
            answer      <= '0;
            EqIndex     <= '0;
            OperandA    <= '0;
            OperandB    <= '0;
            OpSel       <= '0;
            Correct     <= 1'b0;
            Wrong       <= 1'b0;
            WrongCount  <= '0;
            SecondsLeft <= '0;
        end else begin
            go_q    <= Go;
            Correct <= 1'b0;
            Wrong   <= 1'b0;
            // With Start low nothing but the edge register moves, so an
            // abort issues no pulse and keeps the score visible.
            if (Start) begin
                case (state)
                    ST_IDLE: begin
                        EqIndex    <= '0;
                        WrongCount <= '0;
                    end
                    ST_LOAD: begin
                        OperandA    <= rom_eq.a;
                        OperandB    <= rom_eq.b;
                        OpSel       <= rom_eq.op;
                        expected    <= calc_expected(rom_eq);
                        SecondsLeft <= SEC_W'(TIMEOUT_S);
                        prescaler   <= '0;
                    end
                    ST_WAIT_ANS: begin
                        if (tick) begin
                            prescaler   <= '0;
                            SecondsLeft <= SecondsLeft - SEC_W'(1);
                        end else begin
                            prescaler <= prescaler + PW'(1);
                        end
                        if (go_edge) begin
                            answer <= DataIn;
                        end else if (timeout) begin
                            Wrong      <= 1'b1;
                            WrongCount <= sat_inc(WrongCount);
                        end
                    end
                    ST_CHECK: begin
                        if (match) begin
                            Correct <= 1'b1;
                            if (EqIndex != LAST_EQ) EqIndex <= EqIndex + 2'd1;
                        end else begin
                            Wrong      <= 1'b1;
                            WrongCount <= sat_inc(WrongCount);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_quiz_sequencer.sv
// Self-checking bench: a round-level model of the quiz is compared with the
// DUT every cycle, plus hand-computed checks at the interesting moments.
module tb_quiz_sequencer;

    localparam int CLK_HZ    = 10;
    localparam int NUM_EQ    = 3;
    localparam int TIMEOUT_S = 3;

    logic       Clock  = 1'b0;
    logic       Resetn = 1'b0;
    logic       Start  = 1'b0;
    logic       Go     = 1'b1;
    logic [6:0] DataIn = '0;
    logic [1:0] EqIndex, OpSel;
    logic [6:0] OperandA, OperandB;
    logic       Correct, Wrong, Busy, Done, NeedSequence;
    logic [3:0] WrongCount;
    logic [4:0] SecondsLeft;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    quiz_sequencer #(.CLK_HZ(CLK_HZ), .NUM_EQ(NUM_EQ), .TIMEOUT_S(TIMEOUT_S)) dut (
        .Clock(Clock), .Resetn(Resetn), .Start(Start), .Go(Go), .DataIn(DataIn),
        .EqIndex(EqIndex), .OperandA(OperandA), .OperandB(OperandB), .OpSel(OpSel),
        .Correct(Correct), .Wrong(Wrong), .WrongCount(WrongCount),
        .SecondsLeft(SecondsLeft), .Busy(Busy), .Done(Done), .NeedSequence(NeedSequence)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Equation table and its answers, written from the game rules.
    int ta [4] = '{12, 30, 6, 25};
    int tb_[4] = '{7, 14, 9, 25};
    int top[4] = '{0, 1, 2, 0};

    function automatic int expect_of(int i);
        case (top[i])
            0:       return (ta[i] + tb_[i]) % 128;
            1:       return (ta[i] - tb_[i] + 128) % 128;
            default: return (ta[i] * tb_[i]) % 128;
        endcase
    endfunction

    // Round-level model: a round is running, an equation is being set up,
    // being waited on (with elapsed cycles), or being judged.
    int m_busy, m_done, m_setup, m_judge, m_eq, m_wrongs, m_elapsed, m_secs;
    int m_a, m_b, m_op, m_ans, m_corr, m_wrg, m_prev_go;

    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            m_busy = 0; m_done = 0; m_setup = 0; m_judge = 0; m_eq = 0;
            m_wrongs = 0; m_elapsed = 0; m_secs = 0; m_a = 0; m_b = 0;
            m_op = 0; m_ans = 0; m_corr = 0; m_wrg = 0; m_prev_go = 1;
        end else begin
            automatic int press = (m_prev_go == 1 && Go == 1'b0) ? 1 : 0;
            m_prev_go = int'(Go);
            m_corr = 0;
            m_wrg  = 0;
            if (m_busy == 0 && m_done == 0) begin
                if (Start) begin
                    m_busy = 1; m_setup = 1; m_eq = 0; m_wrongs = 0;
                end
            end else if (!Start) begin
                m_busy = 0; m_done = 0; m_setup = 0; m_judge = 0;
            end else if (m_done == 0) begin
                if (m_setup != 0) begin
                    m_a = ta[m_eq]; m_b = tb_[m_eq]; m_op = top[m_eq];
                    m_elapsed = 0; m_secs = TIMEOUT_S; m_setup = 0;
                end else if (m_judge != 0) begin
                    m_judge = 0;
                    if (m_ans == expect_of(m_eq)) begin
                        m_corr = 1;
                        if (m_eq == NUM_EQ - 1) begin
                            m_busy = 0; m_done = 1;
                        end else begin
                            m_eq++; m_setup = 1;
                        end
                    end else begin
                        m_wrg = 1; m_wrongs = (m_wrongs < 15) ? m_wrongs + 1 : 15; m_setup = 1;
                    end
                end else begin
                    m_elapsed++;
                    m_secs = TIMEOUT_S - m_elapsed / CLK_HZ;
                    if (press != 0) begin
                        m_judge = 1; m_ans = int'(DataIn);
                    end else if (m_elapsed == TIMEOUT_S * CLK_HZ) begin
                        m_wrg = 1; m_wrongs = (m_wrongs < 15) ? m_wrongs + 1 : 15; m_setup = 1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge Clock) begin
        if (Resetn && chk_en) begin
            chk("EqIndex",      int'(EqIndex),      m_eq);
            chk("OperandA",     int'(OperandA),     m_a);
            chk("OperandB",     int'(OperandB),     m_b);
            chk("OpSel",        int'(OpSel),        m_op);
            chk("Correct",      int'(Correct),      m_corr);
            chk("Wrong",        int'(Wrong),        m_wrg);
            chk("WrongCount",   int'(WrongCount),   m_wrongs);
            chk("SecondsLeft",  int'(SecondsLeft),  m_secs);
            chk("Busy",         int'(Busy),         m_busy);
            chk("Done",         int'(Done),         m_done);
            chk("NeedSequence", int'(NeedSequence), (m_done != 0 && m_wrongs != 0) ? 1 : 0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge Clock);
        #2;
    endtask

    // One Go press; verdict pulse expected two clocks after the edge.
    task automatic answer(input int v, input bit good);
        DataIn = 7'(v);
        Go = 1'b0;
        cyc(1);
        Go = 1'b1;
        DataIn = 7'($urandom_range(0, 127));
        chk("no_pulse_in_edge_cycle", int'(Correct) + int'(Wrong), 0);
        cyc(1);
        chk("correct_pulse", int'(Correct), int'(good));
        chk("wrong_pulse",   int'(Wrong),   int'(!good));
        cyc(1);
    endtask

    task automatic new_round();
        Start = 1'b0;
        cyc(1);
        Start = 1'b1;
        cyc(2);
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_outs"}, int'(EqIndex) + int'(OperandA) + int'(OperandB) + int'(OpSel)
            + int'(Correct) + int'(Wrong) + int'(WrongCount) + int'(SecondsLeft)
            + int'(Busy) + int'(Done) + int'(NeedSequence), 0);
    endtask

    initial begin
        int nc, nw;
        cyc(2);
        all_zero("reset");
        Resetn = 1'b1;
        cyc(1);
        chk_en = 1'b1;

        // Round 1: all correct.
        Start = 1'b1;
        cyc(2);
        chk("first_eq", int'(EqIndex), 0);
        chk("first_a", int'(OperandA), 12);
        chk("first_b", int'(OperandB), 7);
        chk("first_op", int'(OpSel), 0);
        chk("first_secs", int'(SecondsLeft), 3);
        chk("first_busy", int'(Busy), 1);
        answer(19, 1'b1);
        chk("eq1_a", int'(OperandA), 30);
        answer(16, 1'b1);
        chk("eq2_op", int'(OpSel), 2);
        answer(54, 1'b1);
        chk("r1_done", int'(Done), 1);
        chk("r1_needseq", int'(NeedSequence), 0);
        chk("r1_wrongs", int'(WrongCount), 0);

        // Round 2: a wrong answer, a timeout, a submit on the final tick.
        new_round();
        answer(20, 1'b0);
        chk("retry_wrongs", int'(WrongCount), 1);
        chk("retry_eq", int'(EqIndex), 0);
        chk("retry_secs", int'(SecondsLeft), 3);
        answer(19, 1'b1);
        cyc(29);
        chk("pre_timeout_secs", int'(SecondsLeft), 1);
        cyc(1);
        chk("timeout_wrong", int'(Wrong), 1);
        chk("timeout_secs", int'(SecondsLeft), 0);
        chk("timeout_wrongs", int'(WrongCount), 2);
        cyc(1);
        chk("reload_eq", int'(EqIndex), 1);
        chk("reload_secs", int'(SecondsLeft), 3);
        cyc(29);
        DataIn = 7'd16;
        Go = 1'b0;
        cyc(1);
        Go = 1'b1;
        chk("race_no_timeout", int'(Wrong), 0);
        chk("race_wrongs", int'(WrongCount), 2);
        cyc(1);
        chk("race_correct", int'(Correct), 1);
        chk("race_next_eq", int'(EqIndex), 2);
        cyc(1);
        answer(54, 1'b1);
        chk("r2_done", int'(Done), 1);
        chk("r2_needseq", int'(NeedSequence), 1);

        // Round 3: Go held low on the last equation.
        new_round();
        answer(19, 1'b1);
        answer(16, 1'b1);
        DataIn = 7'd54;
        Go = 1'b0;
        nc = 0;
        nw = 0;
        repeat (50) begin
            cyc(1);
            nc += int'(Correct);
            nw += int'(Wrong);
        end
        Go = 1'b1;
        chk("held_go_corrects", nc, 1);
        chk("held_go_wrongs", nw, 0);
        chk("held_go_done", int'(Done), 1);

        // Round 4: abort during WAIT_ANS after one mistake.
        new_round();
        answer(5, 1'b0);
        cyc(3);
        Start = 1'b0;
        cyc(1);
        chk("abort_busy", int'(Busy), 0);
        chk("abort_pulses", int'(Correct) + int'(Wrong), 0);
        chk("abort_keeps_wrongs", int'(WrongCount), 1);

        // Round 5: saturate the mistake counter.
        Start = 1'b1;
        cyc(2);
        chk("new_round_clears", int'(WrongCount), 0);
        repeat (16) answer(0, 1'b0);
        chk("saturated", int'(WrongCount), 15);
        chk("sat_eq", int'(EqIndex), 0);

        // Asynchronous reset while in CHECK.
        DataIn = 7'd19;
        Go = 1'b0;
        cyc(1);
        chk("pre_reset_busy", int'(Busy), 1);
        Resetn = 1'b0;
        #1;
        all_zero("async_reset");
        Go = 1'b1;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/quiz_sequencer.md
Name: quiz_sequencer

Overview:
- Controller for the equation phase of the alarm game. Steps through NUM_EQ stored equations, presents operands to the display/VGA path and captures the player's answer from DataIn on a Go key press.
- Judges each answer against the computed result and runs a per-equation countdown timer.
- Reports completion and whether any mistake occurred, so the top FSM can choose between its SEQUENCER and DONE paths.

Parameters:
- CLK_HZ, 50000000, clock cycles per one-second tick
- NUM_EQ, 3, number of equations per round (1..4)
- TIMEOUT_S, 20, seconds allowed per equation attempt (1..31)

Ports:
- Clock  in  1  system clock
- Resetn  in  1  asynchronous active-low reset
- Start  in  1  level; high = round enabled, low = abort to IDLE
- Go  in  1  active-low key, already synchronised; a falling edge submits DataIn
- DataIn  in  7  player answer, unsigned
- EqIndex  out  2  index of the current equation
- OperandA  out  7  left operand of the current equation
- OperandB  out  7  right operand of the current equation
- OpSel  out  2  operator: 0 add, 1 sub, 2 mul
- Correct  out  1  one-cycle pulse on a right answer
- Wrong  out  1  one-cycle pulse on a wrong answer or timeout
- WrongCount  out  4  total mistakes this round, saturates at 15
- SecondsLeft  out  5  remaining seconds for the current attempt
- Busy  out  1  high in LOAD, WAIT_ANS and CHECK
- Done  out  1  level, high in DONE
- NeedSequence  out  1  level, high in DONE when WrongCount != 0

Behaviour:
- Reset (Resetn low, async): state IDLE; all outputs 0; prescaler 0; Go edge register = 1.
- IDLE: if Start=1, go to LOAD next cycle and clear EqIndex and WrongCount.
- LOAD (1 cycle):
  - Latch OperandA, OperandB and OpSel from equation_rom[EqIndex].
  - Compute Expected into a 7-bit register: add = a+b mod 128; sub = a-b mod 128; mul = low 7 bits of a*b.
  - SecondsLeft <= TIMEOUT_S; prescaler <= 0. Go to WAIT_ANS.
- WAIT_ANS:
  - Prescaler counts 0..CLK_HZ-1; at wrap, SecondsLeft decrements.
  - A Go falling edge (Go_q=1, Go=0) goes to CHECK with DataIn latched.
  - SecondsLeft reaching 0 (the tick that makes it 0) counts as a timeout: Wrong pulse, WrongCount+1 (saturating), return to LOAD with the same EqIndex.
  - Go edge and timeout tick in the same cycle: the Go edge wins and no timeout is counted.
- CHECK (1 cycle):
  - Answer == Expected: Correct pulse. If EqIndex == NUM_EQ-1 go to DONE, else EqIndex+1 and go to LOAD.
  - Answer != Expected: Wrong pulse, WrongCount+1 (saturating), go to LOAD (same equation, timer restarts).
- Latency: Go edge to Correct/Wrong pulse = 2 clocks (edge detect, then CHECK).
- DONE: holds until Start=0, then goes to IDLE. Operands hold their last values.
- Start=0 in any non-IDLE state: go to IDLE next cycle. No pulses are issued on that transition, and WrongCount is retained until the next round begins.
- Holding Go low produces exactly one submission per press.
- DataIn is sampled only on the submit cycle; changes at other times are ignored.

Decomposition:
- Shared package quiz_pkg:
  - Op codes OP_ADD=0, OP_SUB=1, OP_MUL=2.
  - State encodings IDLE/LOAD/WAIT_ANS/CHECK/DONE.
  - Width constants ANS_W=7, SEC_W=5.
- Sub-module equation_rom: combinational, 2-bit index in, {a[6:0], b[6:0], op[1:0]} out.
  - Contents: 0:{12,7,ADD}=19, 1:{30,14,SUB}=16, 2:{6,9,MUL}=54, 3:{25,25,ADD}=50.

Test Plan (CLK_HZ=10, TIMEOUT_S=3, NUM_EQ=3):
- Reset release, Start=1: EqIndex=0, A=12, B=7, OpSel=0, SecondsLeft=3, Busy=1, all pulses 0.
- Answer 19, 16, 54, each with a single Go press: Correct pulses 2 clocks after each edge, Done=1, NeedSequence=0, WrongCount=0.
- Eq0 answered 20: Wrong pulse, WrongCount=1, EqIndex stays 0, SecondsLeft reloads to 3. Then 19 is accepted; finishing the round gives NeedSequence=1.
- No Go for 30 clocks on eq1: Wrong at SecondsLeft=0, WrongCount+1, eq1 reloaded. Go edge on the same cycle as the final tick: CHECK runs and no timeout is counted.
- Go held low for 50 clocks: exactly one CHECK. Start dropped mid-WAIT_ANS: IDLE next cycle, Busy=0, no pulse.
- 16 consecutive wrong answers: WrongCount saturates at 15. Resetn asserted mid-CHECK: all outputs 0 immediately.
